// File: rtl/uop_sequencer_pkg.sv
// Shared frontend definitions for the micro-op sequencer: widths, FSM states
// and the held instruction payload.
package uop_sequencer_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned UOP_IDX_W = 2;
    localparam int unsigned CNT_W     = 32;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } seq_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            exc;
    } uop_payload_t;

endpackage

// File: rtl/uop_sequencer_if.sv
// Decode-1 to decode-2 micro-op handshake bundle; slave is the sequencer,
// master is the surrounding pipeline.
interface uop_sequencer_if;
    import uop_sequencer_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [XLEN-1:0]      pc_in;
    logic [XLEN-1:0]      instruction_in;
    logic                 exception_in;
    logic [UOP_IDX_W-1:0] uop_count;

    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      pc_out;
    logic [XLEN-1:0]      instruction_out;
    logic                 exception_out;
    logic [UOP_IDX_W-1:0] uop_idx;
    logic                 eoi;

    logic                 flush;
    logic [CNT_W-1:0]     instr_cnt;

    modport slave (
        input  in_valid, pc_in, instruction_in, exception_in, uop_count,
        input  out_ready, flush,
        output in_ready, out_valid, pc_out, instruction_out, exception_out,
        output uop_idx, eoi, instr_cnt
    );

    modport master (
        output in_valid, pc_in, instruction_in, exception_in, uop_count,
        output out_ready, flush,
        input  in_ready, out_valid, pc_out, instruction_out, exception_out,
        input  uop_idx, eoi, instr_cnt
    );

endinterface

// File: rtl/uop_idx_counter.sv
// Tracks the current micro-op index against the instruction's uop total and
// decodes end-of-instruction from registered state only.
module uop_idx_counter
    import uop_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic                 i_load,
    input  logic                 i_advance,
    input  logic                 i_exc,
    input  logic [UOP_IDX_W-1:0] i_total,
    output logic [UOP_IDX_W-1:0] o_idx,
    output logic                 o_eoi
);

    logic [UOP_IDX_W-1:0] r_idx;
    logic [UOP_IDX_W-1:0] r_total;

    // Advance is only issued while idx < total, so the increment never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx   <= '0;
            r_total <= '0;
        end else begin
            if (i_clear || i_load) begin
                r_idx <= '0;
            end else if (i_advance) begin
                r_idx <= r_idx + UOP_IDX_W'(1);
            end
            if (i_load) begin
                r_total <= i_total;
            end
        end
    end

    assign o_idx = r_idx;
    assign o_eoi = (r_idx == r_total) || i_exc;

endmodule

// File: rtl/uop_sequencer.sv
// Splits each decoded instruction into 1..4 micro-ops, streaming them to
// decode-2 with zero-bubble back-to-back acceptance and flush support.
module uop_sequencer
    import uop_sequencer_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    uop_sequencer_if.slave  bus
);

    seq_state_e           r_state;
    seq_state_e           w_state_nxt;
    uop_payload_t         r_payload;
    logic [CNT_W-1:0]     r_instr_cnt;

    logic                 w_out_valid;
    logic                 w_in_ready;
    logic                 w_out_hs;
    logic                 w_last_hs;
    logic                 w_accept;
    logic                 w_eoi;
    logic [UOP_IDX_W-1:0] w_idx;

    assign w_out_hs  = (r_state == ISSUE) && bus.out_ready;
    assign w_last_hs = w_out_hs && w_eoi;
    assign w_accept  = bus.in_valid && w_in_ready;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: flush overrides; an accept keeps or enters ISSUE
    always_comb begin
        w_state_nxt = r_state;
        if (bus.flush) begin
            w_state_nxt = IDLE;
        end else if (w_accept) begin
            w_state_nxt = ISSUE;
        end else if (w_last_hs) begin
            w_state_nxt = IDLE;
        end
    end

    // Handshake outputs
    always_comb begin
        w_out_valid = 1'b0;
        w_in_ready  = 1'b0;
        w_out_valid = (r_state == ISSUE);
        w_in_ready  = ((r_state == IDLE) || w_last_hs) && !bus.flush;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_payload <= '0;
        end else if (w_accept) begin
            r_payload <= '{pc:    bus.pc_in,
                           instr: bus.instruction_in,
                           exc:   bus.exception_in};
        end
    end

    // A flushed instruction is never counted, even if its last uop handshakes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instr_cnt <= '0;
        end else if (w_last_hs && !bus.flush) begin
            r_instr_cnt <= r_instr_cnt + CNT_W'(1);
        end
    end

    uop_idx_counter u_idx_counter (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (bus.flush),
        .i_load    (w_accept),
        .i_advance (w_out_hs && !w_eoi && !bus.flush),
        .i_exc     (r_payload.exc),
        .i_total   (bus.uop_count),
        .o_idx     (w_idx),
        .o_eoi     (w_eoi)
    );

    assign bus.in_ready        = w_in_ready;
    assign bus.out_valid       = w_out_valid;
    assign bus.eoi             = w_eoi;
    assign bus.uop_idx         = w_idx;
    assign bus.pc_out          = r_payload.pc;
    assign bus.instruction_out = r_payload.instr;
    assign bus.exception_out   = r_payload.exc;
    assign bus.instr_cnt       = r_instr_cnt;

endmodule

// File: tb/tb_uop_sequencer.sv
// Self-checking bench for uop_sequencer: directed scenarios plus random
// traffic compared against a queue-of-expected-uops reference model.
module tb_uop_sequencer;
    import uop_sequencer_pkg::*;

    logic clk;
    logic rst;

    uop_sequencer_if u_if ();

    uop_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
        logic [1:0]  idx;
        logic        eoi;
    } exp_uop_t;

    exp_uop_t    q[$];
    logic [31:0] m_cnt;
    int          n_checks;
    int          n_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic m_in_ready();
        return ((q.size() == 0) || (u_if.out_ready && q[0].eoi)) && !u_if.flush;
    endfunction

    task automatic check_outputs();
        chk("out_valid", 32'(u_if.out_valid), 32'(q.size() != 0));
        chk("in_ready",  32'(u_if.in_ready),  32'(m_in_ready()));
        chk("instr_cnt", u_if.instr_cnt, m_cnt);
        if (q.size() != 0) begin
            chk("pc_out",        u_if.pc_out,               q[0].pc);
            chk("instr_out",     u_if.instruction_out,      q[0].instr);
            chk("exception_out", 32'(u_if.exception_out),   32'(q[0].exc));
            chk("uop_idx",       32'(u_if.uop_idx),         32'(q[0].idx));
            chk("eoi",           32'(u_if.eoi),             32'(q[0].eoi));
        end
    endtask

    // One clock: drive at negedge, check before the edge, update model at the edge.
    task automatic cycle(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                         input logic exc, input logic [1:0] cnt, input logic ordy,
                         input logic fl);
        logic rdy, hs, last;
        exp_uop_t e;
        u_if.in_valid       = iv;
        u_if.pc_in          = pc;
        u_if.instruction_in = ins;
        u_if.exception_in   = exc;
        u_if.uop_count      = cnt;
        u_if.out_ready      = ordy;
        u_if.flush          = fl;
        #1;
        check_outputs();
        rdy  = m_in_ready();
        hs   = (q.size() != 0) && ordy;
        last = hs && q[0].eoi;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (hs) void'(q.pop_front());
            if (last) m_cnt = m_cnt + 32'd1;
            if (iv && rdy) begin
                if (exc) begin
                    e = '{pc: pc, instr: ins, exc: 1'b1, idx: 2'd0, eoi: 1'b1};
                    q.push_back(e);
                end else begin
                    for (int i = 0; i <= int'(cnt); i++) begin
                        e = '{pc: pc, instr: ins, exc: 1'b0, idx: 2'(i), eoi: (i == int'(cnt))};
                        q.push_back(e);
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy, input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, 1'b0, 2'd0, ordy, 1'b0);
    endtask

    task automatic check_reset_values();
        chk("rst_out_valid", 32'(u_if.out_valid), 32'd0);
        chk("rst_in_ready",  32'(u_if.in_ready),  32'd1);
        chk("rst_eoi",       32'(u_if.eoi),       32'd1);
        chk("rst_uop_idx",   32'(u_if.uop_idx),   32'd0);
        chk("rst_pc_out",    u_if.pc_out,          32'd0);
        chk("rst_instr_out", u_if.instruction_out, 32'd0);
        chk("rst_exc_out",   32'(u_if.exception_out), 32'd0);
        chk("rst_instr_cnt", u_if.instr_cnt,       32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_cnt    = 32'd0;
        rst                 = 1'b0;
        u_if.in_valid       = 1'b0;
        u_if.pc_in          = 32'h0;
        u_if.instruction_in = 32'h0;
        u_if.exception_in   = 1'b0;
        u_if.uop_count      = 2'd0;
        u_if.out_ready      = 1'b0;
        u_if.flush          = 1'b0;
        #2;
        check_reset_values();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Three-uop instruction streams idx 0,1,2
        cycle(1'b1, 32'h0000_1000, 32'hDEAD_0001, 1'b0, 2'd2, 1'b1, 1'b0);
        idle(1'b1, 4);

        // Back-to-back, no bubble
        cycle(1'b1, 32'h0000_2000, 32'hA000_0000, 1'b0, 2'd0, 1'b1, 1'b0);
        cycle(1'b1, 32'h0000_2004, 32'hA000_0004, 1'b0, 2'd1, 1'b1, 1'b0);
        idle(1'b1, 3);

        // Faulting instruction collapses to one uop
        cycle(1'b1, 32'h0000_3000, 32'hBAD0_0000, 1'b1, 2'd3, 1'b1, 1'b0);
        idle(1'b1, 2);

        // Backpressure at idx 1 for four cycles
        cycle(1'b1, 32'h0000_4000, 32'h1234_5678, 1'b0, 2'd3, 1'b1, 1'b0);
        idle(1'b1, 1);
        idle(1'b0, 4);
        idle(1'b1, 4);

        // Flush at idx 1 with a competing accept
        cycle(1'b1, 32'h0000_5000, 32'h5555_0000, 1'b0, 2'd3, 1'b1, 1'b0);
        idle(1'b1, 1);
        cycle(1'b1, 32'h0000_5100, 32'h5555_1111, 1'b0, 2'd0, 1'b1, 1'b1);
        idle(1'b1, 2);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 9) < 7), $urandom, $urandom,
                  ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
        end
        idle(1'b1, 6);

        // Asynchronous reset mid-instruction
        cycle(1'b1, 32'h0000_6000, 32'h6666_0000, 1'b0, 2'd3, 1'b1, 1'b0);
        idle(1'b0, 1);
        rst = 1'b0;
        #1;
        check_reset_values();
        q.delete();
        m_cnt = 32'd0;
        @(negedge clk);
        rst = 1'b1;
        idle(1'b1, 3);

        // Completed-instruction counter wraps
        cycle(1'b1, 32'h0000_7000, 32'h7777_0000, 1'b0, 2'd0, 1'b0, 1'b0);
        force dut.r_instr_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_instr_cnt;
        m_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        idle(1'b1, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uop_sequencer.md
UOP_SEQUENCER -- requirements
Module: uop_sequencer

Interface
REQ-001 SHALL have one clock and reset: clk input 1 (rising-edge clock); rst input 1 (reset, asynchronous, active-low).
REQ-002 SHALL have in_valid input 1 (d1 presents a decoded instruction) and in_ready output 1 (sequencer accepts it).
REQ-003 SHALL have pc_in input 32, instruction_in input 32, exception_in input 1 (fault tag) and uop_count input 2 (number of uops minus 1, giving 1..4).
REQ-004 SHALL have out_valid output 1 (uop presented to d2_TOP) and out_ready input 1 (d2 accepts it).
REQ-005 SHALL have pc_out output 32, instruction_out output 32, exception_out output 1, uop_idx output 2 (index of the current uop) and eoi output 1 (last uop of the instruction).
REQ-006 SHALL have flush input 1 (discard the in-flight instruction) and instr_cnt output 32 (count of completed instructions).

Function
REQ-007 SHALL have two states, IDLE and ISSUE; out_valid SHALL be 1 exactly in ISSUE.
REQ-008 in_ready SHALL be (IDLE or (out_valid and out_ready and eoi)) and not flush.
REQ-009 An accept (in_valid and in_ready) SHALL register pc, instruction, exception and total = uop_count, set idx to 0, and enter or stay in ISSUE.
REQ-010 eoi SHALL be (idx == total) or exc_q, decoded combinationally from registers only.
REQ-011 If exception_in is 1 at accept, exactly one uop SHALL be emitted with exception_out = 1 and eoi = 1, regardless of uop_count.
REQ-012 An output handshake with eoi = 0 SHALL increment idx by 1; held fields SHALL be unchanged.
REQ-013 An output handshake with eoi = 1 SHALL go to ISSUE with new data if a same-cycle accept occurs, else to IDLE.
REQ-014 Back-to-back instructions SHALL incur zero bubble cycles.
REQ-015 With out_valid = 1 and out_ready = 0, all outputs SHALL hold stable.
REQ-016 Accept-to-first-out_valid latency SHALL be 1 cycle.
REQ-017 Outputs other than eoi, out_valid and in_ready SHALL be driven directly from registers.
REQ-018 flush SHALL take priority over all events: next state IDLE, idx 0, no accept, and instr_cnt not incremented even if eoi handshakes in the same cycle.
REQ-019 instr_cnt SHALL increment on each eoi handshake and wrap from 0xFFFFFFFF to 0.
REQ-020 idx SHALL never exceed total; the 2-bit arithmetic SHALL not wrap in normal operation.
REQ-021 In IDLE, pc_out, instruction_out and uop_idx SHALL hold their last values; consumers SHALL ignore them.

Reset
REQ-022 rst low SHALL immediately force state IDLE, out_valid 0, idx 0, total 0, exc_q 0, pc/instruction registers 0 and instr_cnt 0, so eoi reads 1 and in_ready reads 1 (absent flush).
REQ-023 Reset asserted mid-instruction SHALL drop the instruction; no uop SHALL emerge after release until a new accept.

Structure
REQ-024 The state enum (IDLE, ISSUE) and UOP_IDX_W = 2 SHALL reside in the shared frontend package.
REQ-025 A single sub-module, uop_idx_counter (idx register, total compare, eoi decode), SHALL be natural; all else SHALL reside in uop_sequencer.

Verification
REQ-026 Accept pc = 0x1000 with uop_count = 2 and out_ready = 1 -> uop_idx 0, 1, 2 on 3 consecutive cycles, eoi only on idx 2, instr_cnt +1.
REQ-027 Two instructions back-to-back (count 0, then count 1) with out_ready = 1 -> 3 consecutive valid cycles, no bubble, eoi on cycles 1 and 3.
REQ-028 Accept with exception_in = 1 and uop_count = 3 -> one uop with exception_out = 1, eoi = 1, uop_idx = 0.
REQ-029 out_ready = 0 for 4 cycles at idx 1 -> all outputs stable for those 4 cycles; resume with idx 2 next.
REQ-030 flush at idx 1 of a count-3 instruction -> out_valid 0 next cycle, in_ready 0 during flush, instr_cnt unchanged.
REQ-031 rst pulsed low mid-ISSUE, and instr_cnt preset to 0xFFFFFFFF followed by one eoi handshake -> reset clears immediately with no clock needed; the counter wraps to 0.
